// File: rtl/io_bel_pkg.sv
// Shared configuration layout for the frame-config bidirectional IO BELs.
package io_bel_pkg;

  localparam int unsigned CH_CFG_BITS  = 5;

  // Bit positions within one channel's configuration slice
  localparam int unsigned CFG_OUT_REG  = 0;
  localparam int unsigned CFG_OE_REG   = 1;
  localparam int unsigned CFG_IN_SYNC2 = 2;
  localparam int unsigned CFG_FILT_EN  = 3;
  localparam int unsigned CFG_IN_INV   = 4;

endpackage

// File: rtl/io_bidir_chan.sv
// One bidirectional IO channel: optional output/tristate registers, 1/2-flop
// input synchroniser, stable-sample glitch filter and optional input inversion.
module io_bidir_chan
  import io_bel_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4,
  parameter int unsigned FILTER_W   = ($clog2(FILTER_LEN) > 1) ? $clog2(FILTER_LEN) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i,
  input  logic                   t,
  input  logic                   o_top,
  input  logic [CH_CFG_BITS-1:0] cfg,
  output logic                   o,
  output logic                   q,
  output logic                   i_top,
  output logic                   t_top
);

  localparam logic [FILTER_W-1:0] CNT_MAX = FILTER_W'(FILTER_LEN - 1);

  logic                i_reg;
  logic                t_reg;
  logic                s1;
  logic                s2;
  logic                f;
  logic [FILTER_W-1:0] cnt;
  logic                p;
  logic                s;

  assign p = o_top ^ cfg[CFG_IN_INV];
  assign s = cfg[CFG_IN_SYNC2] ? s2 : s1;

  // Filter runs even when bypassed so enabling it yields an already-settled value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_reg <= 1'b0;
      t_reg <= 1'b1;
      s1    <= 1'b0;
      s2    <= 1'b0;
      f     <= 1'b0;
      cnt   <= '0;
    end else begin
      i_reg <= i;
      t_reg <= t;
      s1    <= p;
      s2    <= s1;
      if (s == f) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        f   <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + FILTER_W'(1);
      end
    end
  end

  assign o     = p;
  assign q     = cfg[CFG_FILT_EN]  ? f     : s;
  assign i_top = cfg[CFG_OUT_REG]  ? i_reg : i;
  assign t_top = cfg[CFG_OE_REG]   ? t_reg : t;

endmodule

// File: rtl/io_bidir_nchan.sv
// NUM_CH-channel bidirectional frame-config IO BEL between switch matrix and pads.
module io_bidir_nchan
  import io_bel_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic                          UserCLK,
  input  logic                          resetn,
  input  logic [NUM_CH-1:0]             I,
  input  logic [NUM_CH-1:0]             T,
  output logic [NUM_CH-1:0]             O,
  output logic [NUM_CH-1:0]             Q,
  output logic [NUM_CH-1:0]             I_top,
  output logic [NUM_CH-1:0]             T_top,
  input  logic [NUM_CH-1:0]             O_top,
  input  logic [NUM_CH*CH_CFG_BITS-1:0] ConfigBits
);

  localparam int unsigned FILTER_W = ($clog2(FILTER_LEN) > 1) ? $clog2(FILTER_LEN) : 1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    io_bidir_chan #(
      .FILTER_LEN (FILTER_LEN),
      .FILTER_W   (FILTER_W)
    ) u_chan (
      .clk   (UserCLK),
      .rst_n (resetn),
      .i     (I[c]),
      .t     (T[c]),
      .o_top (O_top[c]),
      .cfg   (ConfigBits[c*CH_CFG_BITS +: CH_CFG_BITS]),
      .o     (O[c]),
      .q     (Q[c]),
      .i_top (I_top[c]),
      .t_top (T_top[c])
    );
  end

endmodule
